// File: rtl/display_value_reg_pkg.sv
// display_value_reg_pkg: shared constants, FSM encoding and BCD helper
// Revision 1.0
`default_nettype none

package display_value_reg_pkg;

  localparam logic        ADDR_DATA    = 1'b0;
  localparam logic        ADDR_CTRL    = 1'b1;
  localparam logic [31:0] DEC_MAX      = 32'd99_999_999;
  localparam logic [31:0] OVF_PATTERN  = 32'hEEEE_EEEE;
  localparam int          SHIFT_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [31:0] bcd_adjust(input logic [31:0] bcd);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_value_reg_bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-cycle double-dabble converter, 32 cycles per run
// Revision 1.0
`default_nettype none

module bin2bcd_seq
  import display_value_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] din,
  output logic        done,
  output logic [31:0] result
);

  logic [31:0] shreg;
  logic [31:0] acc;
  logic [31:0] adj;
  logic [4:0]  cnt;
  logic        running;

  always_comb adj = bcd_adjust(acc);

  // Asserted during the final iteration; the result is complete right after that edge.
  assign done   = running && (cnt == 5'(SHIFT_CYCLES - 1));
  assign result = acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      shreg   <= din;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (abort) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (running) begin
      acc   <= {adj[30:0], shreg[31]};
      shreg <= {shreg[30:0], 1'b0};
      cnt   <= cnt + 5'd1;
      if (done) running <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_value_reg.sv
// display_value_reg: CPU-writable display value register with hex/decimal presentation
// Revision 1.0
`default_nettype none

module display_value_reg
  import display_value_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        io_wr,
  input  logic        io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic [31:0] value,
  output logic        io_out_en,
  output logic        busy,
  output logic        overflow
);

  state_t      state;
  logic [31:0] data_reg;
  logic        ctrl_en;
  logic        ctrl_dec;
  logic        ovf_pending;

  logic        wr_data;
  logic        wr_ctrl;
  logic [31:0] data_next;
  logic        dec_next;
  logic        conv_start;
  logic        conv_abort;
  logic        conv_done;
  logic [31:0] conv_result;

  // Every write requests an update using the register contents as they will be after it.
  assign wr_data    = io_wr && (io_addr == ADDR_DATA);
  assign wr_ctrl    = io_wr && (io_addr == ADDR_CTRL);
  assign data_next  = wr_data ? io_wdata : data_reg;
  assign dec_next   = wr_ctrl ? io_wdata[1] : ctrl_dec;
  assign conv_start = io_wr && dec_next;
  assign conv_abort = io_wr && !dec_next;

  assign busy      = (state != IDLE);
  assign io_out_en = ctrl_en;
  assign io_rdata  = (io_addr == ADDR_CTRL) ? {27'b0, busy, overflow, 1'b0, ctrl_dec, ctrl_en}
                                            : data_reg;

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (conv_start),
    .abort  (conv_abort),
    .din    (data_next),
    .done   (conv_done),
    .result (conv_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      data_reg    <= '0;
      ctrl_en     <= 1'b0;
      ctrl_dec    <= 1'b0;
      value       <= '0;
      overflow    <= 1'b0;
      ovf_pending <= 1'b0;
    end else begin
      if (wr_data) data_reg <= io_wdata;
      if (wr_ctrl) begin
        ctrl_en  <= io_wdata[0];
        ctrl_dec <= io_wdata[1];
      end
      if (io_wr) begin
        if (dec_next) begin
          state       <= SHIFT;
          ovf_pending <= (data_next > DEC_MAX);
        end else begin
          state    <= IDLE;
          value    <= data_next;
          overflow <= 1'b0;
        end
      end else begin
        case (state)
          SHIFT:   if (conv_done) state <= COMMIT;
          COMMIT: begin
            value    <= ovf_pending ? OVF_PATTERN : conv_result;
            overflow <= ovf_pending;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_value_reg.sv
// tb_display_value_reg: directed + random stimulus against a countdown reference model
// Revision 1.0
`default_nettype none

module tb_display_value_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        io_wr = 1'b0;
  logic        io_addr = 1'b0;
  logic [31:0] io_wdata = '0;
  logic [31:0] io_rdata;
  logic [31:0] value;
  logic        io_out_en;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  display_value_reg dut (
    .clk       (clk),
    .rst       (rst),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .value     (value),
    .io_out_en (io_out_en),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a pending decimal result lands 33 edges after the write that started it.
  logic [31:0] m_data, m_value, m_target;
  logic        m_en, m_dec, m_ovf, m_tovf;
  int          m_left;

  function automatic logic [31:0] to_bcd(input logic [31:0] x);
    logic [31:0] r;
    longint unsigned v;
    r = '0;
    v = x;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_data = '0; m_value = '0; m_target = '0;
    m_en = 0; m_dec = 0; m_ovf = 0; m_tovf = 0; m_left = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else if (io_wr) begin
      if (io_addr) begin
        m_en  = io_wdata[0];
        m_dec = io_wdata[1];
      end else begin
        m_data = io_wdata;
      end
      if (m_dec) begin
        m_left   = 33;
        m_tovf   = (m_data > 32'd99_999_999);
        m_target = m_tovf ? 32'hEEEE_EEEE : to_bcd(m_data);
      end else begin
        m_left  = 0;
        m_value = m_data;
        m_ovf   = 1'b0;
      end
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_value = m_target;
        m_ovf   = m_tovf;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("value", value, m_value);
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("busy", 32'(busy), 32'(m_left > 0));
      check("io_out_en", 32'(io_out_en), 32'(m_en));
      check("io_rdata", io_rdata,
            io_addr ? {27'b0, (m_left > 0), m_ovf, 1'b0, m_dec, m_en} : m_data);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic a, input logic [31:0] d);
    io_wr = 1'b1; io_addr = a; io_wdata = d;
    @(posedge clk);
    #1;
    io_wr = 1'b0;
  endtask

  int n;
  int r;
  logic [31:0] d;

  initial begin
    rst = 1'b0;
    cmp_en = 1'b1;
    idle(3);
    check("reset_value", value, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b1;

    // Hex mode
    do_write(1'b1, 32'h1);
    do_write(1'b0, 32'hDEAD_BEEF);
    check("hex_value", value, 32'hDEAD_BEEF);
    check("hex_busy", 32'(busy), 32'h0);
    check("hex_out_en", 32'(io_out_en), 32'h1);

    // Decimal conversion length and result
    do_write(1'b1, 32'h3);
    do_write(1'b0, 32'd12_345_678);
    n = 0;
    while (busy && n < 100) begin
      n++;
      idle(1);
    end
    check("dec_busy_cycles", 32'(n), 32'd33);
    check("dec_value", value, 32'h1234_5678);
    check("dec_overflow", 32'(overflow), 32'h0);

    // Range boundary
    do_write(1'b0, 32'd99_999_999);
    idle(40);
    check("max_value", value, 32'h9999_9999);
    check("max_overflow", 32'(overflow), 32'h0);
    do_write(1'b0, 32'd100_000_000);
    idle(40);
    check("ovf_value", value, 32'hEEEE_EEEE);
    check("ovf_overflow", 32'(overflow), 32'h1);

    // Abort by a newer write
    do_write(1'b0, 32'd5);
    idle(9);
    do_write(1'b0, 32'd42);
    idle(32);
    check("abort_pending", value, 32'hEEEE_EEEE);
    idle(1);
    check("abort_value", value, 32'h0000_0042);
    check("abort_busy", 32'(busy), 32'h0);

    // Reset in the middle of a conversion
    do_write(1'b0, 32'd7);
    idle(14);
    rst = 1'b0;
    #2;
    check("rst_value", value, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_out_en", 32'(io_out_en), 32'h0);
    idle(1);
    rst = 1'b1;
    do_write(1'b0, 32'h1);
    check("post_rst_hex", value, 32'h1);

    // Switch to hex while converting
    do_write(1'b1, 32'h3);
    do_write(1'b0, 32'd7);
    idle(9);
    do_write(1'b1, 32'h1);
    check("mode_value", value, 32'h0000_0007);
    check("mode_busy", 32'(busy), 32'h0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      io_addr = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 199);
      if (r < 5) begin
        case ($urandom_range(0, 3))
          0: d = $urandom;
          1: d = $urandom_range(0, 99_999_999);
          2: d = 32'd99_999_998 + 32'($urandom_range(0, 3));
          default: d = $urandom_range(0, 999);
        endcase
        if (io_addr) d = 32'($urandom_range(0, 3));
        do_write(io_addr, d);
      end else if (r == 199) begin
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
      end else begin
        idle(1);
      end
    end
    idle(40);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
